// File: rtl/ram_bist.sv
// ram_bist: March-style built-in self-test for a single-port RAM. It owns the
// RAM's addr/din/write_en and runs four elements:
//   up(w BG), up(r BG, w ~BG), down(r ~BG, w BG), down(r BG)
// then reports pass/fail.
// Ports: clk/rst (async active-high), start (one-cycle request),
//        mem_addr/mem_din/mem_write_en/mem_dout (RAM side),
//        busy/done/pass (status), fail_addr/fail_data (first-failure log).
// Optional: define RAM_BIST_FAIL_LOG_EN to capture the first failing address
// and data; otherwise fail_addr/fail_data are constant zero.
// Parameters: READ_LATENCY = 0 (async read) or 1 (registered BRAM read).

module ram_bist #(
    parameter int               WIDTH        = 16,
    parameter int               ADDR_WIDTH   = 8,
    parameter int               READ_LATENCY = 0,
    parameter logic [WIDTH-1:0] BG           = WIDTH'(16'hA5A5)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_din,
    output logic                  mem_write_en,
    input  logic [WIDTH-1:0]      mem_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0]      fail_data
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_M0_W  = 4'd1;
    localparam logic [3:0] S_M1_R  = 4'd2;
    localparam logic [3:0] S_M1_WT = 4'd3;
    localparam logic [3:0] S_M1_W  = 4'd4;
    localparam logic [3:0] S_M2_R  = 4'd5;
    localparam logic [3:0] S_M2_WT = 4'd6;
    localparam logic [3:0] S_M2_W  = 4'd7;
    localparam logic [3:0] S_M3_R  = 4'd8;
    localparam logic [3:0] S_M3_WT = 4'd9;
    localparam logic [3:0] S_FIN   = 4'd10;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    // With a registered read the data for the *_R address arrives one cycle
    // later, so a wait state is inserted and the compare moves into it.
    localparam bit REG_RD = (READ_LATENCY == 1);

    logic [3:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [WIDTH-1:0]      din_q,   din_d;
    logic                  we_q,    we_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;
    logic                  pass_q,  pass_d;

    logic                  cmp_en;
    logic [WIDTH-1:0]      exp_dat;
    logic                  mismatch;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        cmp_en  = 1'b0;
        exp_dat = BG;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_M0_W;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b1;
                end
            end
            S_M0_W: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_M1_R;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_M1_R: begin
                exp_dat = BG;
                if (REG_RD) begin
                    state_d = S_M1_WT;
                end else begin
                    cmp_en  = 1'b1;
                    state_d = S_M1_W;
                end
            end
            S_M1_WT: begin
                exp_dat = BG;
                cmp_en  = 1'b1;
                state_d = S_M1_W;
            end
            S_M1_W: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_M2_R;
                    addr_d  = ADDR_LAST;
                end else begin
                    state_d = S_M1_R;
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            S_M2_R: begin
                exp_dat = ~BG;
                if (REG_RD) begin
                    state_d = S_M2_WT;
                end else begin
                    cmp_en  = 1'b1;
                    state_d = S_M2_W;
                end
            end
            S_M2_WT: begin
                exp_dat = ~BG;
                cmp_en  = 1'b1;
                state_d = S_M2_W;
            end
            S_M2_W: begin
                if (addr_q == '0) begin
                    state_d = S_M3_R;
                    addr_d  = ADDR_LAST;
                end else begin
                    state_d = S_M2_R;
                    addr_d  = addr_q - ADDR_ONE;
                end
            end
            S_M3_R, S_M3_WT: begin
                exp_dat = BG;
                if (REG_RD && (state_q == S_M3_R)) begin
                    state_d = S_M3_WT;
                end else begin
                    cmp_en = 1'b1;
                    if (addr_q == '0) begin
                        // busy drops on entry to FIN; done follows one cycle later.
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_M3_R;
                        addr_d  = addr_q - ADDR_ONE;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        mismatch = cmp_en && (mem_dout != exp_dat);
        if (mismatch) begin
            pass_d = 1'b0;
        end

        // RAM-side outputs are registered, so they are decoded from the
        // state being entered. din holds its last value on read cycles.
        we_d  = (state_d == S_M0_W) || (state_d == S_M1_W) || (state_d == S_M2_W);
        din_d = din_q;
        if ((state_d == S_M0_W) || (state_d == S_M2_W)) begin
            din_d = BG;
        end else if (state_d == S_M1_W) begin
            din_d = ~BG;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_din      = din_q;
    assign mem_write_en = we_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;

`ifdef RAM_BIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [WIDTH-1:0]      fail_data_q;
    logic                  start_acc;

    assign start_acc = (state_q == S_IDLE) && start;

    // pass_q is still 1 exactly until the first mismatch of a run, so it
    // doubles as the "nothing logged yet" flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (start_acc) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (mismatch && pass_q) begin
            fail_addr_q <= addr_q;
            fail_data_q <= mem_dout;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: two instances (async read and registered read) share
// start/rst and each drives its own RAM model with an optional stuck-at bit.
module tb_ram_bist;

    localparam int          W  = 16;
    localparam int          AW = 8;
    localparam int          N  = 256;
    localparam logic [W-1:0] BG = 16'hA5A5;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  din;
    } op_t;

    typedef struct {
        int            cycles;
        int            busy_cycles;
        bit            pass;
        logic [AW-1:0] fa;
        logic [W-1:0]  fd;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic [AW-1:0] a0, a1, fa0, fa1;
    logic [W-1:0]  din0, din1, dout0, dout1, fd0, fd1, rd0, rd1;
    logic          we0, we1, busy0, busy1, done0, done1, pass0, pass1;

    // Stuck-at fault applied on the RAM read path.
    logic          f_en;
    logic [AW-1:0] f_adr;
    logic [W-1:0]  f_mask;
    logic          f_val;

    logic [W-1:0] ram0 [N];
    logic [W-1:0] ram1 [N];

    int vectors = 0;
    int errors  = 0;

    op_t  op_q  [2][$];
    res_t res_q [2][$];

    logic [W-1:0] mm [2][N];
    bit            m_pass [2];
    logic [AW-1:0] m_fa   [2];
    logic [W-1:0]  m_fd   [2];

    int cyc [2];
    int bcyc[2];
    bit trk [2];
    bit pb  [2];
    bit pd  [2];

    always #5 clk = ~clk;

    ram_bist #(.WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(0), .BG(BG)) u0 (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(a0), .mem_din(din0), .mem_write_en(we0), .mem_dout(dout0),
        .busy(busy0), .done(done0), .pass(pass0),
        .fail_addr(fa0), .fail_data(fd0)
    );

    ram_bist #(.WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(1), .BG(BG)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(a1), .mem_din(din1), .mem_write_en(we1), .mem_dout(dout1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(fa1), .fail_data(fd1)
    );

    // RAM models: async read for u0, registered read for u1.
    assign rd0   = (f_en && a0 == f_adr) ? (f_val ? (ram0[a0] | f_mask) : (ram0[a0] & ~f_mask)) : ram0[a0];
    assign rd1   = (f_en && a1 == f_adr) ? (f_val ? (ram1[a1] | f_mask) : (ram1[a1] & ~f_mask)) : ram1[a1];
    assign dout0 = rd0;

    always @(posedge clk) begin
        if (we0) ram0[a0] <= din0;
        if (we1) ram1[a1] <= din1;
        dout1 <= rd1;
    end

    function automatic logic [W-1:0] faulty(logic [W-1:0] v, logic [AW-1:0] a);
        if (f_en && a == f_adr) return f_val ? (v | f_mask) : (v & ~f_mask);
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: the march algorithm itself ----------
    task automatic m_wr(int k, int a, logic [W-1:0] d);
        mm[k][a] = d;
        op_q[k].push_back(op_t'{1'b1, AW'(a), d});
    endtask

    task automatic m_rd(int k, int a, logic [W-1:0] e);
        logic [W-1:0] v;
        v = faulty(mm[k][a], AW'(a));
        // one access cycle per read, plus a wait cycle for the registered RAM
        repeat (k + 1) op_q[k].push_back(op_t'{1'b0, AW'(a), {W{1'b0}}});
        if (v != e && m_pass[k]) begin
            m_pass[k] = 1'b0;
            m_fa[k]   = AW'(a);
            m_fd[k]   = v;
        end
    endtask

    task automatic model_run(int k);
        res_t r;
        m_pass[k] = 1'b1;
        m_fa[k]   = '0;
        m_fd[k]   = '0;
        for (int a = 0; a < N; a++) m_wr(k, a, BG);
        for (int a = 0; a < N; a++) begin m_rd(k, a, BG);  m_wr(k, a, ~BG); end
        for (int a = N - 1; a >= 0; a--) begin m_rd(k, a, ~BG); m_wr(k, a, BG); end
        for (int a = N - 1; a >= 0; a--) m_rd(k, a, BG);
        r.busy_cycles = (k == 1) ? 9 * N : 6 * N;
        r.cycles      = r.busy_cycles + 1;
        r.pass        = m_pass[k];
`ifdef RAM_BIST_FAIL_LOG_EN
        r.fa = m_fa[k];
        r.fd = m_fd[k];
`else
        r.fa = '0;
        r.fd = '0;
`endif
        res_q[k].push_back(r);
    endtask

    // ---------------- monitor --------------------------------------------
    task automatic mon(int k, logic b, logic d, logic we, logic [AW-1:0] ad,
                       logic [W-1:0] di, logic ps, logic [AW-1:0] fa, logic [W-1:0] fd);
        op_t  e;
        res_t r;
        if (trk[k]) cyc[k]++;
        if (b) begin
            if (!pb[k]) begin
                trk[k]  = 1'b1;
                cyc[k]  = 0;
                bcyc[k] = 0;
            end
            bcyc[k]++;
            if (op_q[k].size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL op_underflow[%0d]: got busy access at addr %0h, expected idle", k, ad);
            end else begin
                e = op_q[k].pop_front();
                check($sformatf("access[%0d]", k), 64'({we, ad, we ? di : {W{1'b0}}}), 64'(e));
            end
        end
        if (d && !pd[k]) begin
            if (res_q[k].size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL result_underflow[%0d]: got done=1, expected no run", k);
            end else begin
                r = res_q[k].pop_front();
                check($sformatf("run_cycles[%0d]", k), 64'(cyc[k]), 64'(r.cycles));
                check($sformatf("busy_cycles[%0d]", k), 64'(bcyc[k]), 64'(r.busy_cycles));
                check($sformatf("pass[%0d]", k), 64'(ps), 64'(r.pass));
                check($sformatf("fail_addr[%0d]", k), 64'(fa), 64'(r.fa));
                check($sformatf("fail_data[%0d]", k), 64'(fd), 64'(r.fd));
            end
            trk[k] = 1'b0;
        end
        pb[k] = b;
        pd[k] = d;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                pb[k]  = 1'b0;
                pd[k]  = 1'b0;
                trk[k] = 1'b0;
            end
        end else begin
            mon(0, busy0, done0, we0, a0, din0, pass0, fa0, fd0);
            mon(1, busy1, done1, we1, a1, din1, pass1, fa1, fd1);
        end
    end

    // ---------------- stimulus -------------------------------------------
    task automatic launch();
        model_run(0);
        model_run(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy0", 64'(busy0), 64'(1));
        check("start_done0", 64'(done0), 64'(0));
        check("start_busy1", 64'(busy1), 64'(1));
        check("start_done1", 64'(done1), 64'(0));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done0 && done1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout: got done0=%0b done1=%0b, expected both 1", done0, done1);
        end
        @(negedge clk);
    endtask

    task automatic set_fault(logic en, logic [AW-1:0] adr, logic [W-1:0] mask, logic val);
        f_en   = en;
        f_adr  = adr;
        f_mask = mask;
        f_val  = val;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        set_fault(1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_outs0", 64'({busy0, done0, pass0, we0, a0, din0, fa0, fd0}), 64'(0));
        check("reset_outs1", 64'({busy1, done1, pass1, we1, a1, din1, fa1, fd1}), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good RAM; a start at cycle 100 and one during u0's FIN are ignored.
        launch();
        repeat (98) @(negedge clk);
        pulse_start();
        n = 0;
        while (busy0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        pulse_start();
        check("fin_start_ignored_busy", 64'(busy0), 64'(0));
        check("fin_start_done", 64'(done0), 64'(1));
        wait_done();

        // Bit 3 stuck at 0 at 0x2C. Bit 3 of BG is 0, so the fault is first
        // seen on the descending ~BG read.
        set_fault(1'b1, 8'h2C, 16'h0008, 1'b0);
        launch();
        wait_done();

        // Same RAM, fault removed: clean result, log cleared.
        set_fault(1'b0, '0, '0, 1'b0);
        launch();
        wait_done();

        // Reset mid-run, while u0 is writing.
        launch();
        repeat (699) @(negedge clk);
        n = 0;
        while (!we0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        check("midrst_busy0", 64'(busy0), 64'(0));
        check("midrst_we0",   64'(we0),   64'(0));
        check("midrst_done0", 64'(done0), 64'(0));
        check("midrst_busy1", 64'(busy1), 64'(0));
        check("midrst_we1",   64'(we1),   64'(0));
        check("midrst_done1", 64'(done1), 64'(0));
        for (int k = 0; k < 2; k++) begin
            op_q[k].delete();
            res_q[k].delete();
        end
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        launch();
        wait_done();

        // Random faults and random ignored starts.
        for (int r = 0; r < 4; r++) begin
            set_fault(1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)),
                      W'(1) << $urandom_range(0, W - 1), 1'($urandom_range(0, 1)));
            launch();
            repeat ($urandom_range(5, 1200)) @(negedge clk);
            pulse_start();
            wait_done();
        end

        for (int k = 0; k < 2; k++) begin
            check($sformatf("leftover_ops[%0d]", k), 64'(op_q[k].size()), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
